// File: rtl/fake_cpu.sv
// fake_cpu: single-cycle MIPS-subset core with one unified, word-addressed memory.
// Fetch, decode, execute and writeback all finish inside a single clk cycle.
module fake_cpu #(
  parameter int MEM_WORDS      = 4096,
  parameter int DATA_BASE_WORD = 2048
) (
  input logic clk,
  input logic reset
);

  // Word index is always taken from byte-address bits [13:2]; MEM_WORDS is a power of two <= 4096.
  localparam int AW = $clog2(MEM_WORDS);
  // Where .data lands is a property of the preloaded image, not of the core itself.
  localparam int unused_data_base_word = DATA_BASE_WORD;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [31:0] PC_A;
  logic [31:0] INS_A;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] rf_q [32];

  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        mem_we;

  logic [11:0] fetch_idx;
  logic [11:0] data_idx;
  logic [31:0] fetch_word;
  logic [31:0] load_word;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_a;
  logic [4:0]  rt_a;
  logic [4:0]  rd_a;
  logic [15:0] imm;
  logic [25:0] jaddr;

  logic [31:0] rs_v;
  logic [31:0] rt_v;
  logic [31:0] sext_imm;
  logic [31:0] zext_imm;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] data_addr;
  logic        unused_bits;

  assign PC_A      = pc_q;
  assign INS_A     = fetch_word;
  assign fetch_idx = PC_A[13:2];

  assign opcode = INS_A[31:26];
  assign rs_a   = INS_A[25:21];
  assign rt_a   = INS_A[20:16];
  assign rd_a   = INS_A[15:11];
  assign funct  = INS_A[5:0];
  assign imm    = INS_A[15:0];
  assign jaddr  = INS_A[25:0];

  // rf_q[0] is never written, so both read ports see zero for r0.
  assign rs_v = rf_q[rs_a];
  assign rt_v = rf_q[rt_a];

  assign sext_imm  = {{16{imm[15]}}, imm};
  assign zext_imm  = {16'h0000, imm};
  assign pc_plus4  = PC_A + 32'd4;
  assign br_target = pc_plus4 + (sext_imm << 2);
  assign j_target  = {pc_plus4[31:28], jaddr, 2'b00};
  assign data_addr = rs_v + sext_imm;
  assign data_idx  = data_addr[13:2];

  assign unused_bits = ^{INS_A[10:6], data_addr[31:14], data_addr[1:0]};

  // Unified memory: combinational fetch and load ports, store lands on the clock edge.
  if (MEM_WORDS > 0) begin : cpumem
    logic [31:0] mem [0:MEM_WORDS-1];

    always_ff @(posedge clk) begin
      if (mem_we) begin
        mem[data_idx[AW-1:0]] <= rt_v;
      end
    end

    assign fetch_word = mem[fetch_idx[AW-1:0]];
    assign load_word  = mem[data_idx[AW-1:0]];
  end

  always_comb begin
    pc_d       = pc_plus4;
    rf_wr_en   = 1'b0;
    rf_wr_addr = rt_a;
    rf_wr_data = 32'h0000_0000;
    mem_we     = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        rf_wr_addr = rd_a;
        case (funct)
          FN_ADD: begin
            rf_wr_en   = 1'b1;
            rf_wr_data = rs_v + rt_v;
          end
          FN_SUB: begin
            rf_wr_en   = 1'b1;
            rf_wr_data = rs_v - rt_v;
          end
          FN_AND: begin
            rf_wr_en   = 1'b1;
            rf_wr_data = rs_v & rt_v;
          end
          FN_OR: begin
            rf_wr_en   = 1'b1;
            rf_wr_data = rs_v | rt_v;
          end
          FN_SLT: begin
            rf_wr_en   = 1'b1;
            rf_wr_data = {31'h0, ($signed(rs_v) < $signed(rt_v))};
          end
          FN_JR: begin
            pc_d = rs_v;
          end
          default: ;
        endcase
      end
      OP_ADDI: begin
        rf_wr_en   = 1'b1;
        rf_wr_data = rs_v + sext_imm;
      end
      OP_ORI: begin
        rf_wr_en   = 1'b1;
        rf_wr_data = rs_v | zext_imm;
      end
      OP_LUI: begin
        rf_wr_en   = 1'b1;
        rf_wr_data = {imm, 16'h0000};
      end
      OP_LW: begin
        rf_wr_en   = 1'b1;
        rf_wr_data = load_word;
      end
      OP_SW: begin
        // Memory has no reset of its own, so a store is suppressed while reset is held.
        mem_we = reset;
      end
      OP_BEQ: begin
        if (rs_v == rt_v) begin
          pc_d = br_target;
        end
      end
      OP_BNE: begin
        if (rs_v != rt_v) begin
          pc_d = br_target;
        end
      end
      OP_J: begin
        pc_d = j_target;
      end
      OP_JAL: begin
        pc_d       = j_target;
        rf_wr_en   = 1'b1;
        rf_wr_addr = 5'd31;
        rf_wr_data = pc_plus4;
      end
      default: ;
    endcase

    if (rf_wr_addr == 5'd0) begin
      rf_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= 32'h0000_0000;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'h0000_0000;
      end
    end else if (rf_wr_en) begin
      rf_q[rf_wr_addr] <= rf_wr_data;
    end
  end

endmodule

// File: tb/tb_fake_cpu.sv
// Bench for fake_cpu: directed programs with known results, then random programs run in
// lockstep against an instruction-level reference model.
module tb_fake_cpu;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  fake_cpu #(.MEM_WORDS(4096), .DATA_BASE_WORD(2048)) dut (
    .clk  (clk),
    .reset(reset)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_mem [4096];
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] a);
    return {op, a};
  endfunction

  task automatic poke(input int idx, input logic [31:0] v);
    dut.cpumem.mem[idx] <= v;
    m_mem[idx] = v;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) poke(i, 32'h0);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: executes one instruction straight from the ISA rules.
  task automatic model_step();
    logic [31:0] ins, a, b, pc4, simm, addr;
    ins  = m_mem[m_pc[13:2]];
    a    = m_reg[ins[25:21]];
    b    = m_reg[ins[20:16]];
    pc4  = m_pc + 32'd4;
    simm = {{16{ins[15]}}, ins[15:0]};
    addr = a + simm;
    m_pc = pc4;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: m_reg[ins[15:11]] = a + b;
        6'h22: m_reg[ins[15:11]] = a - b;
        6'h24: m_reg[ins[15:11]] = a & b;
        6'h25: m_reg[ins[15:11]] = a | b;
        6'h2A: m_reg[ins[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h08: m_pc = a;
        default: ;
      endcase
      6'h08: m_reg[ins[20:16]] = a + simm;
      6'h0D: m_reg[ins[20:16]] = a | {16'h0, ins[15:0]};
      6'h0F: m_reg[ins[20:16]] = {ins[15:0], 16'h0};
      6'h23: m_reg[ins[20:16]] = m_mem[addr[13:2]];
      6'h2B: m_mem[addr[13:2]] = b;
      6'h04: if (a == b) m_pc = pc4 + (simm << 2);
      6'h05: if (a != b) m_pc = pc4 + (simm << 2);
      6'h02: m_pc = {pc4[31:28], ins[25:0], 2'b00};
      6'h03: begin
        m_reg[31] = pc4;
        m_pc = {pc4[31:28], ins[25:0], 2'b00};
      end
      default: ;
    endcase
    m_reg[0] = 32'h0;
  endtask

  function automatic logic [31:0] rand_ins(input int i);
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm, dofs;
    rs   = 5'($urandom_range(0, 7));
    rt   = 5'($urandom_range(0, 7));
    rd   = 5'($urandom_range(0, 7));
    imm  = 16'($urandom);
    dofs = 16'h2000 + 16'($urandom_range(0, 15) * 4) + 16'($urandom_range(0, 3));
    case ($urandom_range(0, 13))
      0:  return enc_r(rs, rt, rd, 6'h20);
      1:  return enc_r(rs, rt, rd, 6'h22);
      2:  return enc_r(rs, rt, rd, 6'h24);
      3:  return enc_r(rs, rt, rd, 6'h25);
      4:  return enc_r(rs, rt, rd, 6'h2A);
      5:  return enc_i(6'h08, rs, rt, imm);
      6:  return enc_i(6'h0D, rs, rt, imm);
      7:  return enc_i(6'h0F, 5'd0, rt, imm);
      8:  return enc_i(6'h2B, 5'd0, rt, dofs);
      9:  return enc_i(6'h23, 5'd0, rt, dofs);
      10: return enc_i(6'h04, rs, rt, 16'($urandom_range(0, 3)));
      11: return enc_i(6'h05, rs, rt, 16'($urandom_range(0, 3)));
      12: return enc_j(6'h03, 26'(i + 1 + int'($urandom_range(0, 3))));
      default: return {6'h3F, 26'($urandom)};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w0, w1, w2, dword, sword;

    // Reset then sequential fetch through three NOP-class words
    hold_reset();
    clear_mem();
    w0 = {6'h3F, 26'($urandom)};
    w1 = {6'h3F, 26'($urandom)};
    w2 = {6'h3F, 26'($urandom)};
    poke(0, w0); poke(1, w1); poke(2, w2);
    release_reset();
    check("rst_pc", dut.PC_A, 32'h0);
    check("rst_ins", dut.INS_A, w0);
    step();
    check("seq_pc4", dut.PC_A, 32'h4);
    check("seq_ins1", dut.INS_A, w1);
    step();
    check("seq_pc8", dut.PC_A, 32'h8);
    check("seq_ins2", dut.INS_A, w2);
    $display("seq: fetch sequence done");

    // ALU program
    hold_reset();
    clear_mem();
    poke(0,  enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    poke(1,  enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
    poke(2,  enc_r(5'd1, 5'd2, 5'd3, 6'h20));
    poke(3,  enc_r(5'd2, 5'd1, 5'd4, 6'h2A));
    poke(4,  enc_r(5'd1, 5'd2, 5'd5, 6'h22));
    poke(5,  enc_r(5'd1, 5'd2, 5'd6, 6'h24));
    poke(6,  enc_r(5'd1, 5'd2, 5'd7, 6'h25));
    poke(7,  enc_r(5'd1, 5'd1, 5'd0, 6'h20));
    poke(8,  enc_r(5'd1, 5'd2, 5'd8, 6'h2A));
    poke(9,  enc_i(6'h0D, 5'd0, 5'd9, 16'h8001));
    poke(10, enc_i(6'h0F, 5'd0, 5'd10, 16'h8001));
    release_reset();
    for (int i = 0; i < 11; i++) step();
    check("alu_r1", dut.rf_q[1], 32'd5);
    check("alu_r2", dut.rf_q[2], 32'hFFFF_FFFD);
    check("alu_add", dut.rf_q[3], 32'd2);
    check("alu_slt", dut.rf_q[4], 32'd1);
    check("alu_sub", dut.rf_q[5], 32'd8);
    check("alu_and", dut.rf_q[6], 32'd5);
    check("alu_or", dut.rf_q[7], 32'hFFFF_FFFD);
    check("alu_r0", dut.rf_q[0], 32'd0);
    check("alu_slt0", dut.rf_q[8], 32'd0);
    check("alu_ori", dut.rf_q[9], 32'h0000_8001);
    check("alu_lui", dut.rf_q[10], 32'h8001_0000);
    check("alu_pc", dut.PC_A, 32'd44);
    $display("alu: program done");

    // Loads/stores incl. preloaded .data and high-address wrap
    hold_reset();
    clear_mem();
    dword = $urandom;
    poke(2048, dword);
    poke(0, enc_i(6'h0F, 5'd0, 5'd1, 16'h0000));
    poke(1, enc_i(6'h0D, 5'd1, 5'd1, 16'h2000));
    poke(2, enc_i(6'h08, 5'd0, 5'd2, 16'h0055));
    poke(3, enc_i(6'h2B, 5'd1, 5'd2, 16'h0004));
    poke(4, enc_i(6'h23, 5'd1, 5'd3, 16'h0004));
    poke(5, enc_i(6'h23, 5'd1, 5'd4, 16'h0000));
    poke(6, enc_i(6'h0F, 5'd0, 5'd6, 16'h0001));
    poke(7, enc_i(6'h23, 5'd6, 5'd7, 16'h2004));
    release_reset();
    for (int i = 0; i < 8; i++) step();
    check("mem_base", dut.rf_q[1], 32'h2000);
    check("mem_sw", dut.cpumem.mem[2049], 32'h55);
    check("mem_lw", dut.rf_q[3], 32'h55);
    check("mem_data", dut.rf_q[4], dword);
    check("mem_wrap", dut.rf_q[7], 32'h55);
    $display("mem: program done");

    // Branches
    hold_reset();
    clear_mem();
    poke(0, enc_i(6'h04, 5'd0, 5'd0, 16'd2));
    poke(3, enc_i(6'h05, 5'd0, 5'd0, 16'd2));
    poke(4, enc_i(6'h08, 5'd0, 5'd1, 16'd1));
    poke(5, enc_i(6'h05, 5'd1, 5'd0, 16'hFFFA));
    release_reset();
    step(); check("beq_taken", dut.PC_A, 32'd12);
    step(); check("bne_not", dut.PC_A, 32'd16);
    step(); check("br_addi", dut.PC_A, 32'd20);
    step(); check("bne_back", dut.PC_A, 32'd0);
    hold_reset();
    poke(0, enc_i(6'h05, 5'd0, 5'd0, 16'd2));
    release_reset();
    step(); check("bne_at0", dut.PC_A, 32'd4);
    $display("br: branch checks done");

    // JAL / JR
    hold_reset();
    clear_mem();
    poke(2, enc_j(6'h03, 26'h10));
    poke(16, enc_r(5'd31, 5'd0, 5'd0, 6'h08));
    release_reset();
    step(); step();
    check("jal_at8", dut.PC_A, 32'd8);
    step();
    check("jal_pc", dut.PC_A, 32'h40);
    check("jal_r31", dut.rf_q[31], 32'd12);
    step();
    check("jr_pc", dut.PC_A, 32'd12);
    $display("jmp: jal/jr done");

    // Reset asserted mid-execution with a pending store at 0x20
    hold_reset();
    clear_mem();
    sword = $urandom;
    poke(2052, sword);
    for (int i = 0; i < 7; i++) poke(i, enc_i(6'h08, 5'd0, 5'(i + 1), 16'(i + 1)));
    poke(8, enc_i(6'h2B, 5'd0, 5'd7, 16'h2010));
    release_reset();
    for (int i = 0; i < 8; i++) step();
    check("mid_pc20", dut.PC_A, 32'h20);
    check("mid_r7", dut.rf_q[7], 32'd7);
    reset = 1'b0;
    #1;
    check("mid_async_pc", dut.PC_A, 32'h0);
    check("mid_ins0", dut.INS_A, m_mem[0]);
    for (int i = 1; i < 32; i++) check("mid_reg_clr", dut.rf_q[i], 32'h0);
    step();
    check("mid_hold_pc", dut.PC_A, 32'h0);
    check("mid_no_sw", dut.cpumem.mem[2052], sword);
    for (int i = 0; i < 9; i++) check("mid_mem_kept", dut.cpumem.mem[i], m_mem[i]);
    release_reset();
    check("mid_rel_pc", dut.PC_A, 32'h0);
    check("mid_rel_ins", dut.INS_A, m_mem[0]);
    step();
    check("mid_restart_pc", dut.PC_A, 32'h4);
    check("mid_restart_r1", dut.rf_q[1], 32'd1);
    $display("rst: mid-execution reset done");

    // Random programs in lockstep with the reference model
    for (int t = 0; t < 4; t++) begin
      hold_reset();
      clear_mem();
      for (int i = 0; i < 40; i++) poke(i, rand_ins(i));
      for (int i = 0; i < 16; i++) poke(2048 + i, $urandom);
      release_reset();
      for (int c = 0; c < 48; c++) begin
        check("rnd_pc", dut.PC_A, m_pc);
        check("rnd_ins", dut.INS_A, m_mem[m_pc[13:2]]);
        model_step();
        step();
        for (int r = 1; r < 8; r++) check("rnd_reg", dut.rf_q[r], m_reg[r]);
        check("rnd_r31", dut.rf_q[31], m_reg[31]);
      end
      for (int i = 0; i < 16; i++) check("rnd_data", dut.cpumem.mem[2048 + i], m_mem[2048 + i]);
      $display("rnd: program %0d done, final pc %h", t, dut.PC_A);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
